display_scan: RTL and testbench

Time-multiplexed 4-digit scan controller for the calculator's seven-segment display. It sits directly upstream of the per-segment decoders (a..g). It holds the 16-bit result word and steps through its four nibbles at a fixed prescaled rate. On each step it presents the current nibble to all decoders in parallel and drives the matching active-low anode. Loads from the calculator core are double-buffered and committed only on digit boundaries, so the display never shows a torn value.

---
 rtl/display_scan.sv | 89 ++++++++
 tb/tb_display_scan.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// Four-digit time-multiplexed scan controller for the seven-segment display.
// Loads are double-buffered and committed only on digit-slot boundaries.
module display_scan #(
    parameter int   SCAN_DIV      = 50000,
    parameter logic BLANK_LEADING = 1'b1
) (
    input  logic        JM1222HM_clk,
    input  logic        JM1222HM_rst,
    input  logic [15:0] JM1222HM_value,
    input  logic        JM1222HM_load,
    output logic [3:0]  JM1222HM_digit,
    output logic [3:0]  JM1222HM_an,
    output logic        JM1222HM_blank,
    output logic        JM1222HM_ack
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PCNT_MAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   pending_q, pending_d;
    logic          pend_q, pend_d;
    logic          ack_q, ack_d;
    logic [3:0]    digit_q, digit_d;
    logic [3:0]    an_q, an_d;
    logic          blank_q, blank_d;
    logic          tick;
    logic [15:0]   upper;

    always_comb begin
        tick      = (pcnt_q == PCNT_MAX);
        pcnt_d    = tick ? '0 : pcnt_q + 1'b1;
        idx_d     = tick ? idx_q + 2'd1 : idx_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        pend_d    = pend_q;
        ack_d     = 1'b0;

        // A load landing on the tick cycle bypasses the pending buffer.
        if (tick) begin
            if (pend_q || JM1222HM_load) begin
                shadow_d = JM1222HM_load ? JM1222HM_value : pending_q;
                pend_d   = 1'b0;
                ack_d    = 1'b1;
            end
        end else if (JM1222HM_load) begin
            pending_d = JM1222HM_value;
            pend_d    = 1'b1;
        end

        // Outputs are derived from the post-edge slot and word so anode and nibble always agree.
        upper   = shadow_d >> {idx_d, 2'b00};
        digit_d = upper[3:0];
        blank_d = (BLANK_LEADING != 1'b0) && (idx_d != 2'd0) && (upper == 16'h0000);
        an_d    = blank_d ? 4'b1111 : ~(4'b0001 << idx_d);
    end

    always_ff @(posedge JM1222HM_clk) begin
        if (JM1222HM_rst) begin
            pcnt_q    <= '0;
            idx_q     <= 2'd0;
            shadow_q  <= 16'h0000;
            pending_q <= 16'h0000;
            pend_q    <= 1'b0;
            ack_q     <= 1'b0;
            digit_q   <= 4'h0;
            an_q      <= 4'b1110;
            blank_q   <= 1'b0;
        end else begin
            pcnt_q    <= pcnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            pend_q    <= pend_d;
            ack_q     <= ack_d;
            digit_q   <= digit_d;
            an_q      <= an_d;
            blank_q   <= blank_d;
        end
    end

    assign JM1222HM_digit = digit_q;
    assign JM1222HM_an    = an_q;
    assign JM1222HM_blank = blank_q;
    assign JM1222HM_ack   = ack_q;

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: two instances (leading-zero blanking on and off) checked
// every cycle against a slot-arithmetic reference model under directed and random stimulus.
module tb_display_scan;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = 16'h0000;
    logic        load = 1'b0;
    logic [3:0]  digit_b, an_b, digit_n, an_n;
    logic        blank_b, ack_b, blank_n, ack_n;

    int checks = 0;
    int failures = 0;

    int          m_cyc = 0;
    logic [15:0] m_shadow = 16'h0000;
    logic [15:0] m_pending = 16'h0000;
    bit          m_pend = 1'b0;
    bit          m_ack = 1'b0;

    always #5 clk = ~clk;

    display_scan #(.SCAN_DIV(DIV), .BLANK_LEADING(1'b1)) dut_blank (
        .JM1222HM_clk(clk), .JM1222HM_rst(rst), .JM1222HM_value(value), .JM1222HM_load(load),
        .JM1222HM_digit(digit_b), .JM1222HM_an(an_b), .JM1222HM_blank(blank_b), .JM1222HM_ack(ack_b)
    );

    display_scan #(.SCAN_DIV(DIV), .BLANK_LEADING(1'b0)) dut_lit (
        .JM1222HM_clk(clk), .JM1222HM_rst(rst), .JM1222HM_value(value), .JM1222HM_load(load),
        .JM1222HM_digit(digit_n), .JM1222HM_an(an_n), .JM1222HM_blank(blank_n), .JM1222HM_ack(ack_n)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Reference: slot is simply elapsed cycles / DIV, modulo four.
    task automatic model_edge(input bit r, input bit l, input logic [15:0] v);
        bit tick;
        if (r) begin
            m_cyc = 0; m_shadow = 0; m_pending = 0; m_pend = 0; m_ack = 0;
        end else begin
            tick  = (m_cyc % DIV) == DIV - 1;
            m_ack = 0;
            if (tick) begin
                if (m_pend || l) begin
                    m_shadow = l ? v : m_pending;
                    m_pend   = 0;
                    m_ack    = 1;
                end
            end else if (l) begin
                m_pending = v;
                m_pend    = 1;
            end
            m_cyc++;
        end
    endtask

    task automatic compare_all();
        int slot, up, nib, blanked, an_exp;
        slot = (m_cyc / DIV) % 4;
        up   = int'(m_shadow) >> (4 * slot);
        nib  = up & 15;
        blanked = (slot != 0 && up == 0) ? 1 : 0;
        an_exp  = blanked ? 15 : (15 ^ (1 << slot));
        check("digit_bl1", int'(digit_b), nib);
        check("an_bl1",    int'(an_b),    an_exp);
        check("blank_bl1", int'(blank_b), blanked);
        check("ack_bl1",   int'(ack_b),   int'(m_ack));
        check("digit_bl0", int'(digit_n), nib);
        check("an_bl0",    int'(an_n),    15 ^ (1 << slot));
        check("blank_bl0", int'(blank_n), 0);
        check("ack_bl0",   int'(ack_n),   int'(m_ack));
    endtask

    task automatic step(input bit r, input bit l, input logic [15:0] v);
        rst = r; load = l; value = v;
        @(posedge clk);
        model_edge(r, l, v);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0000);
    endtask

    task automatic align_pcnt(input int p);
        while ((m_cyc % DIV) != p) step(0, 0, 16'h0000);
    endtask

    int ack_seen;

    initial begin
        // reset held, including a load that must be ignored
        step(1, 0, 16'h0000);
        step(1, 1, 16'hBEEF);
        step(1, 0, 16'h0000);
        idle(20);

        align_pcnt(1);
        step(0, 1, 16'h1234);
        idle(16);

        align_pcnt(0);
        step(0, 1, 16'h0050);
        idle(16);
        align_pcnt(2);
        step(0, 1, 16'h0A00);
        idle(16);

        // overwrite before tick: one ack only
        align_pcnt(0);
        ack_seen = 0;
        step(0, 1, 16'h1111);
        ack_seen += int'(ack_b);
        step(0, 0, 16'h0000);
        ack_seen += int'(ack_b);
        step(0, 1, 16'h2222);
        ack_seen += int'(ack_b);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 16'h0000);
            ack_seen += int'(ack_b);
        end
        check("overwrite_ack_count", ack_seen, 1);
        idle(10);

        align_pcnt(3);
        step(0, 1, 16'h9876);
        idle(16);

        // reset mid-scan with a pending load
        while (!(((m_cyc / DIV) % 4) == 2 && (m_cyc % DIV) == 0)) step(0, 0, 16'h0000);
        step(0, 1, 16'h5555);
        step(1, 0, 16'h0000);
        ack_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 16'h0000);
            ack_seen += int'(ack_b);
        end
        check("no_ack_after_reset", ack_seen, 0);

        for (int i = 0; i < 3000; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            case ($urandom_range(0, 3))
                0: v = v & 16'h000F;
                1: v = v & 16'h00FF;
                2: v = v & 16'h0FFF;
                default: ;
            endcase
            step(($urandom_range(0, 149) == 0), ($urandom_range(0, 5) == 0), v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
